pll_seq_csr: RTL and testbench
==============================

Name: pll_seq_csr

Overview:
- Multi-channel successor to the single-PLL control/status register block on the SPI register bus.
- Host requests power per PLL; a per-channel sequencer handles the rest: powers the PLL, waits for stable lock with timeout, then moves the image buffer read clock from SPI to pixel clock.
- On power-down or lock loss it moves the clock back to SPI before the PLL is stopped.
- Exposes synchronized lock, run status and sticky fault flags.

Parameters:
- PLL_CSR_BASE, 'h40, base opcode; block decodes BASE..BASE+2.
- N_PLL, 1, number of PLL channels, legal range 1..4.
- PWR_REQ_DEFAULT, 0, reset value of the N_PLL-bit power-request register.
- LOCK_STABLE_CYCLES, 4, consecutive synchronized-lock cycles required before RUN (≥1).
- LOCK_TIMEOUT_CYCLES, 255, cycles allowed in WAIT_LOCK before FAULT (≥ LOCK_STABLE_CYCLES).
- GUARD_CYCLES, 2, cycles in DRAIN between clock switch and PLL power-down (≥1).

Ports:
- spi_clock_in  input  1  SPI clock; all flops update on its falling edge.
- spi_reset_n_in  input  1  asynchronous active-low reset.
- opcode_in  input  8  register address.
- operand_in  input  8  write data.
- operand_valid_in  input  1  write strobe; a write occurs on every cycle it is high with a decoded opcode.
- response_out  output  8  read data, combinational from opcode_in and registers.
- pllpowerdown_n  output  N_PLL  1 = PLL powered.
- image_buffer_read_en  output  N_PLL  1 = image buffer on SPI clock, 0 = pixel clock.
- pll_locked  input  N_PLL  raw PLL lock, asynchronous to spi_clock_in.

Behaviour:
- Reset (async, any state): request = PWR_REQ_DEFAULT, all channels OFF, sticky flags 0, counters 0.
- Reset output values: pllpowerdown_n = 0, image_buffer_read_en = all 1.
- Outputs are registered state decodes:
  - OFF and FAULT: powerdown_n 0, read_en 1.
  - WAIT_LOCK and DRAIN: powerdown_n 1, read_en 1.
  - RUN: powerdown_n 1, read_en 0.
- Registers:
  - BASE+0 W: request[N_PLL-1:0] = operand[N_PLL-1:0]. R: request.
  - BASE+1 R: [3:0] lock_sync, [7:4] run flags (state==RUN). Writes ignored.
  - BASE+2 R: [3:0] timeout_fault, [7:4] lock_lost. W: write-1-to-clear, same layout.
  - Bits for channel ≥ N_PLL and undecoded opcodes read 0.
- Per-channel FSM:
  - OFF: request=1 → WAIT_LOCK, stable and timeout counters cleared.
  - WAIT_LOCK:
    - request=0 → OFF.
    - Each cycle lock_sync=1 increments the stable counter; lock_sync=0 clears it.
    - Stable counter reaching LOCK_STABLE_CYCLES → RUN.
    - Timeout counter reaching LOCK_TIMEOUT_CYCLES without RUN → FAULT, set timeout_fault.
    - If stable completion and timeout occur on the same cycle, RUN wins.
  - RUN:
    - request=0 → DRAIN.
    - lock_sync=0 → WAIT_LOCK with counters cleared, set lock_lost. read_en reaches 1 on that same edge.
    - If both conditions hold in the same cycle, lock loss is handled first: WAIT_LOCK, then request=0 takes it to OFF.
  - DRAIN: counts GUARD_CYCLES, then → OFF. A request raised during DRAIN is not acted on until OFF is reached; it then restarts normally.
  - FAULT: stays until timeout_fault is cleared via W1C → OFF. If request is still 1, OFF → WAIT_LOCK on the next cycle.
- Sticky flags: if a set and a W1C clear occur on the same cycle, the set wins.
- Counters saturate and never wrap. Widths are $clog2(param+1).
- Timing depends on SPI activity: all timing counts spi_clock_in edges, and the sequencer advances only while SPI is clocked. The host polls BASE+1 to supply those clocks.

Optional Feature:
- PLL_LOCK_CDC_EN defined: each pll_locked bit passes through a 2-flop synchronizer before lock_sync and the FSM. Lock-related transitions are delayed by 2 cycles.
- Not defined: lock_sync = pll_locked directly. Intended for simulation and for designs where lock is already synchronous.

Decomposition:
- Package pll_seq_pkg:
  - Channel state enum: OFF, WAIT_LOCK, RUN, DRAIN, FAULT.
  - Opcode offsets: REG_CTRL=0, REG_STATUS=1, REG_FAULT=2.
  - MAX_PLL=4.
- Sub-module pll_seq_channel: one FSM, its counters and its sticky flags. Instantiated N_PLL times by generate.
- Top level holds register decode, the request register, response mux and optional synchronizers.

Test Plan:
- Normal power-up, N_PLL=2, CDC off: write BASE+0=0x01; pll_locked[0] high from cycle 3. Required: powerdown_n[0]=1 at cycle 1, RUN 4 stable cycles after lock, read_en[0]=0, BASE+1 reads 0x11. Channel 1 untouched.
- Lock never asserts, LOCK_TIMEOUT_CYCLES=16: write request=1. Required: FAULT after 16 cycles, powerdown_n=0, BASE+2 reads 0x01. Write BASE+2=0x01 with request still 1: re-enters WAIT_LOCK.
- Lock loss: in RUN, drop pll_locked[0] for 1 cycle. Required: read_en[0]=1 on the next edge, BASE+2 bit4=1. Lock returns: RUN again after 4 stable cycles.
- Power-down guard: in RUN, write request=0. Required: read_en=1 immediately, powerdown_n stays 1 for GUARD_CYCLES=2, then 0.
- Simultaneous events: W1C of lock_lost on the same cycle as a new lock drop → flag remains 1. Lock glitch of 2 cycles in WAIT_LOCK → stable counter restarts.
- Reset mid-sequence: assert spi_reset_n_in during WAIT_LOCK or DRAIN. Required: outputs immediately powerdown_n=0, read_en=1, flags 0. With PWR_REQ_DEFAULT=1, sequence restarts after reset release. Repeat with PLL_LOCK_CDC_EN and check the 2-cycle delay.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and constants for
// the multi-channel PLL sequencer CSR block.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    OFF,
    WAIT_LOCK,
    RUN,
    DRAIN,
    FAULT
  } ch_state_t;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_FAULT  = 2;

  localparam int MAX_PLL = 4;

endpackage

// File: rtl/pll_seq_channel.sv
// pll_seq_channel: one PLL power/lock sequencer
// with stable, timeout and guard counters.
module pll_seq_channel
  import pll_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = 4,
  parameter int LOCK_TIMEOUT_CYCLES = 255,
  parameter int GUARD_CYCLES        = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic lock,
  input  logic clr_tf,
  input  logic clr_ll,
  output logic pwr_n,
  output logic rd_en,
  output logic run,
  output logic timeout_fault,
  output logic lock_lost
);

  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  localparam logic [SW-1:0] STB_MAX =
    SW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX =
    TW'(LOCK_TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GRD_MAX =
    GW'(GUARD_CYCLES);

  ch_state_t state_q, state_d;

  logic [SW-1:0] stb_q, stb_d, stb_inc;
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [GW-1:0] grd_q, grd_d, grd_inc;

  logic tf_q, tf_d, set_tf;
  logic ll_q, ll_d, set_ll;

  assign stb_inc = (stb_q == STB_MAX) ?
    stb_q : stb_q + SW'(1);
  assign tmo_inc = (tmo_q == TMO_MAX) ?
    tmo_q : tmo_q + TW'(1);
  assign grd_inc = (grd_q == GRD_MAX) ?
    grd_q : grd_q + GW'(1);

  // Next state, counters and flag set pulses
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    tmo_d   = tmo_q;
    grd_d   = grd_q;
    set_tf  = 1'b0;
    set_ll  = 1'b0;
    unique case (state_q)
      OFF: begin
        if (req) begin
          state_d = WAIT_LOCK;
          stb_d   = '0;
          tmo_d   = '0;
        end
      end
      WAIT_LOCK: begin
        if (!req) begin
          state_d = OFF;
        end else begin
          stb_d = lock ? stb_inc : '0;
          tmo_d = tmo_inc;
          if (lock && stb_inc == STB_MAX) begin
            state_d = RUN;
          end else if (tmo_inc == TMO_MAX) begin
            state_d = FAULT;
            set_tf  = 1'b1;
          end
        end
      end
      RUN: begin
        if (!lock) begin
          state_d = WAIT_LOCK;
          stb_d   = '0;
          tmo_d   = '0;
          set_ll  = 1'b1;
        end else if (!req) begin
          state_d = DRAIN;
          grd_d   = '0;
        end
      end
      DRAIN: begin
        grd_d = grd_inc;
        if (grd_inc == GRD_MAX) begin
          state_d = OFF;
        end
      end
      FAULT: begin
        if (clr_tf) begin
          state_d = OFF;
        end
      end
      default: begin
        state_d = OFF;
      end
    endcase
  end

  // Sticky flags: a set beats a same-cycle clear
  always_comb begin
    tf_d = (tf_q & ~clr_tf) | set_tf;
    ll_d = (ll_q & ~clr_ll) | set_ll;
  end

  // State, counter and flag registers
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      stb_q   <= '0;
      tmo_q   <= '0;
      grd_q   <= '0;
      tf_q    <= 1'b0;
      ll_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      tmo_q   <= tmo_d;
      grd_q   <= grd_d;
      tf_q    <= tf_d;
      ll_q    <= ll_d;
    end
  end

  assign pwr_n = (state_q == WAIT_LOCK) ||
                 (state_q == RUN) ||
                 (state_q == DRAIN);
  assign rd_en = (state_q != RUN);
  assign run   = (state_q == RUN);

  assign timeout_fault = tf_q;
  assign lock_lost     = ll_q;

endmodule

// File: rtl/pll_seq_csr.sv
// pll_seq_csr: multi-PLL sequencer CSR block on SPI bus.
// Define PLL_LOCK_CDC_EN to add 2-flop lock synchronizers.
module pll_seq_csr
  import pll_seq_pkg::*;
#(
  parameter int PLL_CSR_BASE        = 'h40,
  parameter int N_PLL               = 1,
  parameter int PWR_REQ_DEFAULT     = 0,
  parameter int LOCK_STABLE_CYCLES  = 4,
  parameter int LOCK_TIMEOUT_CYCLES = 255,
  parameter int GUARD_CYCLES        = 2
) (
  input  logic             spi_clock_in,
  input  logic             spi_reset_n_in,
  input  logic [7:0]       opcode_in,
  input  logic [7:0]       operand_in,
  input  logic             operand_valid_in,
  output logic [7:0]       response_out,
  output logic [N_PLL-1:0] pllpowerdown_n,
  output logic [N_PLL-1:0] image_buffer_read_en,
  input  logic [N_PLL-1:0] pll_locked
);

  localparam logic [7:0] OP_CTRL =
    8'(PLL_CSR_BASE + REG_CTRL);
  localparam logic [7:0] OP_STATUS =
    8'(PLL_CSR_BASE + REG_STATUS);
  localparam logic [7:0] OP_FAULT =
    8'(PLL_CSR_BASE + REG_FAULT);

  logic hit_ctrl, hit_status, hit_fault;
  logic wr_ctrl, wr_fault;

  logic [N_PLL-1:0] req_q;
  logic [N_PLL-1:0] lock_sync;
  logic [N_PLL-1:0] run;
  logic [N_PLL-1:0] tf;
  logic [N_PLL-1:0] ll;
  logic [N_PLL-1:0] clr_tf;
  logic [N_PLL-1:0] clr_ll;

  logic [MAX_PLL-1:0] req_w, lck_w, run_w;
  logic [MAX_PLL-1:0] tf_w, ll_w;

  logic unused_operand;

  assign hit_ctrl   = (opcode_in == OP_CTRL);
  assign hit_status = (opcode_in == OP_STATUS);
  assign hit_fault  = (opcode_in == OP_FAULT);

  assign wr_ctrl  = operand_valid_in & hit_ctrl;
  assign wr_fault = operand_valid_in & hit_fault;

  assign clr_tf = wr_fault ?
    operand_in[N_PLL-1:0] : '0;
  assign clr_ll = wr_fault ?
    operand_in[N_PLL+3:4] : '0;

  assign unused_operand = ^operand_in;

  // Host power-request register
  always_ff @(negedge spi_clock_in or negedge spi_reset_n_in) begin
    if (!spi_reset_n_in) begin
      req_q <= N_PLL'(PWR_REQ_DEFAULT);
    end else if (wr_ctrl) begin
      req_q <= operand_in[N_PLL-1:0];
    end
  end

`ifdef PLL_LOCK_CDC_EN
  logic [N_PLL-1:0] sync1, sync2;

  // Two-flop synchronizer for the raw lock inputs
  always_ff @(negedge spi_clock_in or negedge spi_reset_n_in) begin
    if (!spi_reset_n_in) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pll_locked;
      sync2 <= sync1;
    end
  end

  assign lock_sync = sync2;
`else
  assign lock_sync = pll_locked;
`endif

  for (genvar i = 0; i < N_PLL; i++) begin : g_ch
    pll_seq_channel #(
      .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
      .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
      .GUARD_CYCLES        (GUARD_CYCLES)
    ) u_ch (
      .clk           (spi_clock_in),
      .rst_n         (spi_reset_n_in),
      .req           (req_q[i]),
      .lock          (lock_sync[i]),
      .clr_tf        (clr_tf[i]),
      .clr_ll        (clr_ll[i]),
      .pwr_n         (pllpowerdown_n[i]),
      .rd_en         (image_buffer_read_en[i]),
      .run           (run[i]),
      .timeout_fault (tf[i]),
      .lock_lost     (ll[i])
    );
  end

  // Widen per-channel vectors to the 4-bit field layout
  always_comb begin
    req_w = '0;
    lck_w = '0;
    run_w = '0;
    tf_w  = '0;
    ll_w  = '0;
    req_w[N_PLL-1:0] = req_q;
    lck_w[N_PLL-1:0] = lock_sync;
    run_w[N_PLL-1:0] = run;
    tf_w[N_PLL-1:0]  = tf;
    ll_w[N_PLL-1:0]  = ll;
  end

  // Read data mux
  always_comb begin
    response_out = '0;
    unique case (1'b1)
      hit_ctrl:   response_out = {4'h0, req_w};
      hit_status: response_out = {run_w, lck_w};
      hit_fault:  response_out = {ll_w, tf_w};
      default:    response_out = '0;
    endcase
  end

endmodule

// File: tb/tb_pll_seq_csr.sv
// tb_pll_seq_csr: randomized and directed bench for
// pll_seq_csr with a behavioural sequencer model.
module tb_pll_seq_csr;

  localparam int NP  = 2;
  localparam int STB = 4;
  localparam int TMO = 16;
  localparam int GRD = 2;
`ifdef PLL_LOCK_CDC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int M_OFF   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;
  localparam int M_FAULT = 4;

  logic          clk = 1'b1;
  logic          rst_n;
  logic [7:0]    opcode;
  logic [7:0]    operand;
  logic          valid;
  logic [7:0]    resp;
  logic [NP-1:0] pwr_n;
  logic [NP-1:0] rd_en;
  logic [NP-1:0] locked;

  always #5 clk = ~clk;

  pll_seq_csr #(
    .PLL_CSR_BASE        ('h40),
    .N_PLL               (NP),
    .PWR_REQ_DEFAULT     (0),
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .GUARD_CYCLES        (GRD)
  ) dut (
    .spi_clock_in         (clk),
    .spi_reset_n_in       (rst_n),
    .opcode_in            (opcode),
    .operand_in           (operand),
    .operand_valid_in     (valid),
    .response_out         (resp),
    .pllpowerdown_n       (pwr_n),
    .image_buffer_read_en (rd_en),
    .pll_locked           (locked)
  );

  int n_cmp;
  int n_err;

  int m_mode [NP];
  int m_stab [NP];
  int m_tmo  [NP];
  int m_grd  [NP];
  bit m_tf   [NP];
  bit m_ll   [NP];
  bit [NP-1:0] m_req;
  bit [NP-1:0] s1;
  bit [NP-1:0] s2;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] cur_sync();
`ifdef PLL_LOCK_CDC_EN
    return s2;
`else
    return locked;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_mode[i] = M_OFF;
      m_stab[i] = 0;
      m_tmo[i]  = 0;
      m_grd[i]  = 0;
      m_tf[i]   = 1'b0;
      m_ll[i]   = 1'b0;
    end
    m_req = '0;
    s1    = '0;
    s2    = '0;
  endtask

  // Advance the model by one falling edge using current inputs
  task automatic model_step();
    logic [NP-1:0] ls;
    bit wr_c, wr_f, r, l, ctf, cll, stf, sll;
    ls   = cur_sync();
    wr_c = valid && (opcode == 8'h40);
    wr_f = valid && (opcode == 8'h42);
    for (int i = 0; i < NP; i++) begin
      r   = m_req[i];
      l   = ls[i];
      ctf = wr_f && operand[i];
      cll = wr_f && operand[4+i];
      stf = 1'b0;
      sll = 1'b0;
      case (m_mode[i])
        M_OFF: if (r) begin
          m_mode[i] = M_WAIT;
          m_stab[i] = 0;
          m_tmo[i]  = 0;
        end
        M_WAIT: if (!r) begin
          m_mode[i] = M_OFF;
        end else begin
          m_stab[i] = l ? m_stab[i] + 1 : 0;
          m_tmo[i]  = m_tmo[i] + 1;
          if (m_stab[i] >= STB) begin
            m_mode[i] = M_RUN;
          end else if (m_tmo[i] >= TMO) begin
            m_mode[i] = M_FAULT;
            stf = 1'b1;
          end
        end
        M_RUN: if (!l) begin
          m_mode[i] = M_WAIT;
          m_stab[i] = 0;
          m_tmo[i]  = 0;
          sll = 1'b1;
        end else if (!r) begin
          m_mode[i] = M_DRAIN;
          m_grd[i]  = 0;
        end
        M_DRAIN: begin
          m_grd[i] = m_grd[i] + 1;
          if (m_grd[i] >= GRD) m_mode[i] = M_OFF;
        end
        M_FAULT: if (ctf) m_mode[i] = M_OFF;
        default: m_mode[i] = M_OFF;
      endcase
      m_tf[i] = (m_tf[i] && !ctf) || stf;
      m_ll[i] = (m_ll[i] && !cll) || sll;
    end
    if (wr_c) m_req = operand[NP-1:0];
    s2 = s1;
    s1 = locked;
  endtask

  function automatic logic [7:0] exp_resp();
    logic [7:0] v;
    logic [NP-1:0] ls;
    v  = '0;
    ls = cur_sync();
    for (int i = 0; i < NP; i++) begin
      if (opcode == 8'h40) v[i] = m_req[i];
      if (opcode == 8'h41) begin
        v[i]   = ls[i];
        v[4+i] = (m_mode[i] == M_RUN);
      end
      if (opcode == 8'h42) begin
        v[i]   = m_tf[i];
        v[4+i] = m_ll[i];
      end
    end
    return v;
  endfunction

  // One SPI cycle: model, falling edge, then compare
  task automatic tick();
    logic [NP-1:0] epw, erd;
    model_step();
    @(negedge clk);
    @(posedge clk);
    for (int i = 0; i < NP; i++) begin
      epw[i] = (m_mode[i] == M_WAIT) ||
               (m_mode[i] == M_RUN) ||
               (m_mode[i] == M_DRAIN);
      erd[i] = (m_mode[i] != M_RUN);
    end
    chk("pwr_n", 8'(pwr_n), 8'(epw));
    chk("rd_en", 8'(rd_en), 8'(erd));
    chk("resp", resp, exp_resp());
  endtask

  task automatic wr(input logic [7:0] op,
                    input logic [7:0] d);
    opcode  = op;
    operand = d;
    valid   = 1'b1;
    tick();
    valid   = 1'b0;
    operand = 8'h00;
    opcode  = 8'h41;
  endtask

  task automatic peek(input string tag,
                      input logic [7:0] op,
                      input logic [7:0] exp);
    opcode = op;
    #1;
    chk(tag, resp, exp);
    opcode = 8'h41;
  endtask

  // Asynchronous reset mid-cycle, checked before any edge
  task automatic do_reset();
    valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_pwr", 8'(pwr_n), 8'h00);
    chk("rst_rd", 8'(rd_en), 8'h03);
    peek("rst_flags", 8'h42, 8'h00);
    peek("rst_req", 8'h40, 8'h00);
    model_reset();
    @(posedge clk);
    rst_n = 1'b1;
  endtask

  int n;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    opcode  = 8'h41;
    operand = 8'h00;
    valid   = 1'b0;
    locked  = '0;
    model_reset();
    #3;
    chk("init_pwr", 8'(pwr_n), 8'h00);
    chk("init_rd", 8'(rd_en), 8'h03);
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    tick();

    // Normal power-up of channel 0
    wr(8'h40, 8'h01);
    tick();
    chk("pu_pwr", 8'(pwr_n), 8'h01);
    chk("pu_rd", 8'(rd_en), 8'h03);
    tick();
    locked[0] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (rd_en[0] && n < 40);
    chk("pu_lat", 8'(n), 8'(STB + LAT));
    chk("pu_stat", resp, 8'h11);
    chk("pu_ch1", 8'(pwr_n[1]), 8'h00);

    // One-cycle lock drop while running
    locked[0] = 1'b0;
    tick();
    locked[0] = 1'b1;
    repeat (LAT) tick();
    chk("ll_rd", 8'(rd_en), 8'h03);
    peek("ll_flag", 8'h42, 8'h10);
    n = 0;
    do begin
      tick();
      n++;
    end while (rd_en[0] && n < 40);
    chk("ll_relock", 8'(n), 8'(STB));

    // W1C of lock_lost on the same edge as a new drop
    locked[0] = 1'b0;
    repeat (LAT) tick();
    wr(8'h42, 8'h10);
    locked[0] = 1'b1;
    peek("w1c_set_wins", 8'h42, 8'h10);
    wr(8'h42, 8'h10);
    peek("w1c_clr", 8'h42, 8'h00);
    n = 0;
    do begin
      tick();
      n++;
    end while (rd_en[0] && n < 40);
    chk("relock2", 8'(rd_en), 8'h02);

    // Lock timeout on channel 1
    wr(8'h40, 8'h03);
    tick();
    chk("to_wait", 8'(pwr_n[1]), 8'h01);
    n = 0;
    do begin
      tick();
      n++;
    end while (pwr_n[1] && n < 40);
    chk("to_lat", 8'(n), 8'(TMO));
    peek("to_flag", 8'h42, 8'h02);
    wr(8'h42, 8'h02);
    peek("to_clr", 8'h42, 8'h00);
    tick();
    chk("to_rearm", 8'(pwr_n[1]), 8'h01);
    locked[1] = 1'b1;
    repeat (STB + LAT + 2) tick();
    peek("both_run", 8'h41, 8'h33);

    // Power-down guard on channel 0
    wr(8'h40, 8'h02);
    chk("pd_rd0", 8'(rd_en[0]), 8'h00);
    tick();
    chk("pd_rd1", 8'(rd_en[0]), 8'h01);
    chk("pd_pw1", 8'(pwr_n[0]), 8'h01);
    tick();
    chk("pd_pw2", 8'(pwr_n[0]), 8'h01);
    tick();
    chk("pd_pw3", 8'(pwr_n[0]), 8'h00);

    // Reset during WAIT_LOCK
    locked[0] = 1'b0;
    wr(8'h40, 8'h01);
    tick();
    do_reset();
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 9) == 0)
          locked[i] = ~locked[i];
      end
      case ($urandom_range(0, 19))
        0, 1: begin
          opcode  = 8'h40;
          operand = 8'($urandom);
          valid   = 1'b1;
        end
        2: begin
          opcode  = 8'h42;
          operand = 8'($urandom);
          valid   = 1'b1;
        end
        3: begin
          opcode  = 8'($urandom);
          operand = 8'($urandom);
          valid   = 1'b1;
        end
        default: begin
          opcode  = 8'(8'h3F + $urandom_range(0, 4));
          operand = 8'($urandom);
          valid   = 1'b0;
        end
      endcase
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        tick();
      end
      valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
